mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_pick_2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared state encoding, latency default and counter width for
//            the two-requester memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int         c_LATENCY_DEF = 2;
    localparam int         c_CNT_W       = 4;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ACCESS   = 2'd1;
    localparam logic [1:0] c_ST_RESP     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_2
// Brief    : Two-way round-robin pick; on a conflict the side not granted
//            last time wins, otherwise the single active requester wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_sel
);

    always_comb begin
        gnt_sel = req1;
        if (req0 && req1) begin
            gnt_sel = ~last_gnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates an instruction-fetch port and a data port onto one
//            fixed-latency memory port; all outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = c_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic        we1,
    input  logic [31:0] wdata1,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last_gnt;
    logic               w_gnt_sel;
    logic               w_any_req;

    assign w_any_req = req0 | req1;

    rr_pick_2 u_rr_pick_2 (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (r_last_gnt),
        .gnt_sel  (w_gnt_sel)
    );

    // mem_sel/mem_addr/mem_wdata double as the grant registers and hold
    // their value after the access; mem_we is only meaningful with mem_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_last_gnt <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= 32'h0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= c_ST_ACCESS;
                        r_cnt      <= c_CNT_LOAD;
                        r_last_gnt <= w_gnt_sel;
                        mem_sel    <= w_gnt_sel;
                        mem_addr   <= w_gnt_sel ? addr1 : addr0;
                        mem_we     <= w_gnt_sel & we1;
                        mem_wdata  <= wdata1;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                c_ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state <= c_ST_RESP;
                        rdata   <= mem_rdata;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        ack0    <= ~mem_sel;
                        ack1    <= mem_sel;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
